restoring_divider: RTL and testbench

Iterative unsigned restoring divider: computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock. It is the subtraction-side counterpart to the team's carry-lookahead adder. Each trial subtraction uses a combinational borrow-lookahead subtractor. It sits behind a simple start/busy/done handshake and is intended for datapaths that need division without a full-array divider.

---
 rtl/divider_pkg.sv | 28 ++
 rtl/borrow_lookahead_subtractor.sv | 59 +++++
 rtl/restoring_divider.sv | 159 +++++++++++++++
 tb/tb_restoring_divider.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// ============================================================================
// Module      : divider_pkg
// Description : Shared types and helpers for the iterative restoring divider.
//               Holds the divider state encoding and the width helper for
//               the iteration counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package divider_pkg;

  // Divider control states. Two bits cover all three states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed for a counter that runs from width-1 down to 0.
  // Clamped to one bit so a degenerate width never yields a zero-width
  // vector.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage : divider_pkg

`default_nettype wire

// File: rtl/borrow_lookahead_subtractor.sv
// ============================================================================
// Module      : borrow_lookahead_subtractor
// Description : Purely combinational unsigned subtractor, diff = a - b.
//               Uses the generate/propagate formulation of the team's
//               carry-lookahead adder, recast for borrows:
//                 G_i = ~a_i & b_i     (bit i creates a borrow)
//                 P_i = ~a_i | b_i     (bit i passes an incoming borrow on)
//                 B_{i+1} = G_i | (P_i & B_i), B_0 = 0
//               borrow_out is high when a < b.
// Ports       : a          - minuend, WIDTH bits
//               b          - subtrahend, WIDTH bits
//               diff       - a - b modulo 2**WIDTH
//               borrow_out - borrow out of the most significant bit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module borrow_lookahead_subtractor #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_b;

  // Per-bit borrow generate and propagate terms.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_gp
      assign w_g[i] = ~a[i] & b[i];
      assign w_p[i] = ~a[i] | b[i];
    end
  endgenerate

  // Borrow chain. Evaluated in one process so the whole chain is a single
  // combinational node; synthesis is free to flatten it into a lookahead tree.
  always_comb begin
    w_b[0] = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_b[i+1] = w_g[i] | (w_p[i] & w_b[i]);
    end
  end

  // Difference bits combine each operand bit with its incoming borrow.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_diff
      assign diff[i] = a[i] ^ b[i] ^ w_b[i];
    end
  endgenerate

  assign borrow_out = w_b[WIDTH];

endmodule : borrow_lookahead_subtractor

`default_nettype wire

// File: rtl/restoring_divider.sv
// ============================================================================
// Module      : restoring_divider
// Description : Iterative unsigned restoring divider. Produces one quotient
//               bit per clock behind a start/busy/done handshake. Each trial
//               subtraction goes through one WIDTH+1-bit borrow-lookahead
//               subtractor.
//               Latency: start sampled at edge k -> busy for WIDTH cycles,
//               done in the cycle after edge k+WIDTH. A zero divisor skips
//               the iterations and raises done in the cycle after edge k.
// Ports       : clk         - rising-edge clock
//               rst         - asynchronous active-high reset
//               start       - request a division (sampled only in IDLE)
//               dividend    - unsigned dividend, sampled with start
//               divisor     - unsigned divisor, sampled with start
//               busy        - high while iterating
//               done        - one-cycle pulse, results valid
//               quotient    - quotient, held until the next accepted start
//               remainder   - remainder, held until the next accepted start
//               div_by_zero - divisor was zero; held with the results
// Parameters  : WIDTH       - operand/result width, must be >= 2
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int c_CNT_W = cnt_width(WIDTH);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic [WIDTH:0]     r_rem;    // partial remainder, one guard bit
  logic [WIDTH-1:0]   r_quo;    // dividend shifts out, quotient shifts in
  logic [WIDTH:0]     r_dvs;    // zero-extended divisor
  logic [c_CNT_W-1:0] r_cnt;    // iterations left after the current one
  logic               r_busy;
  logic               r_done;
  logic               r_dz;

  // --------------------------------------------------------------------------
  // Trial subtraction
  // --------------------------------------------------------------------------
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;
  logic           w_borrow;

  // Bring down the next dividend bit next to the partial remainder.
  assign w_shifted = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};

  borrow_lookahead_subtractor #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .a          (w_shifted),
    .b          (r_dvs),
    .diff       (w_trial),
    .borrow_out (w_borrow)
  );

  // --------------------------------------------------------------------------
  // Control FSM and datapath update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              // Divide by zero: saturated quotient, dividend passes through
              // as the remainder, and the iterations are skipped entirely.
              r_quo   <= '1;
              r_rem   <= {1'b0, dividend};
              r_dz    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_dvs   <= {1'b0, divisor};
              r_rem   <= '0;
              r_quo   <= dividend;
              r_cnt   <= c_CNT_W'(WIDTH - 1);
              r_dz    <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= RUN;
            end
          end
        end

        RUN: begin
          // Keep the difference only when it did not go negative; otherwise
          // restore the shifted value. The new quotient bit is the inverse
          // of the borrow.
          r_rem <= w_borrow ? w_shifted : w_trial;
          r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        DONE: begin
          // start is deliberately not looked at here, so it is dropped.
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The guard bit only absorbs the shifted-in value during a trial; a kept
  // remainder is always below the divisor, so it is never part of a result.
  logic w_unused_rem_msb;
  assign w_unused_rem_msb = r_rem[WIDTH];

  // --------------------------------------------------------------------------
  // Outputs: straight from registers
  // --------------------------------------------------------------------------
  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quo;
  assign remainder   = r_rem[WIDTH-1:0];
  assign div_by_zero = r_dz;

endmodule : restoring_divider

`default_nettype wire

// File: tb/tb_restoring_divider.sv
// ============================================================================
// Module      : tb_restoring_divider
// Description : Self-checking bench for restoring_divider (WIDTH = 8).
//               Directed vector table, handshake corner sequences and a
//               random sweep against the / and % operators.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_restoring_divider;

  localparam int c_W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [c_W-1:0] dividend;
  logic [c_W-1:0] divisor;
  logic           busy;
  logic           done;
  logic [c_W-1:0] quotient;
  logic [c_W-1:0] remainder;
  logic           div_by_zero;

  int total = 0;
  int bad   = 0;

  restoring_divider #(
    .WIDTH (c_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Issue one division and wait for done. n = edges after the start edge at
  // which done was seen, bc = cycles with busy high, to = timeout.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        output int n, output int bc, output bit to);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    n  = 0;
    bc = 0;
    to = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      n++;
      if (n > 40) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] eq, input logic [7:0] er, input logic edz);
    int n, bc;
    bit to;
    do_div(a, b, n, bc, to);
    chk({tag, " timeout"}, 32'(to), 32'd0);
    if (!to) begin
      chk({tag, " quotient"}, 32'(quotient), 32'(eq));
      chk({tag, " remainder"}, 32'(remainder), 32'(er));
      chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
      chk({tag, " latency"}, 32'(n), edz ? 32'd0 : 32'd8);
      chk({tag, " busy_cycles"}, 32'(bc), edz ? 32'd0 : 32'd8);
      chk({tag, " busy_with_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, " q_held"}, 32'(quotient), 32'(eq));
    end
  endtask

  initial begin
    int n, bc, dones;
    bit to;
    logic [7:0] ra, rb;

    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,   dz: 1'b0};
    vecs[1] = '{a: 8'd3,   b: 8'd10,  q: 8'd0,   r: 8'd3,   dz: 1'b0};
    vecs[2] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   dz: 1'b0};
    vecs[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   dz: 1'b0};
    vecs[4] = '{a: 8'd5,   b: 8'd0,   q: 8'hFF,  r: 8'd5,   dz: 1'b1};
    vecs[5] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,   dz: 1'b0};
    vecs[6] = '{a: 8'd128, b: 8'd16,  q: 8'd8,   r: 8'd0,   dz: 1'b0};
    vecs[7] = '{a: 8'd254, b: 8'd255, q: 8'd0,   r: 8'd254, dz: 1'b0};
    vecs[8] = '{a: 8'd200, b: 8'd128, q: 8'd1,   r: 8'd72,  dz: 1'b0};
    vecs[9] = '{a: 8'd0,   b: 8'd0,   q: 8'hFF,  r: 8'd0,   dz: 1'b1};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);

    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                    vecs[i].q, vecs[i].r, vecs[i].dz);
    end

    // Starts during RUN and during DONE must be dropped.
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd9;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    to    = 1'b0;
    n     = 0;
    while (done !== 1'b1) begin
      if (n == 2) begin
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (n > 40) begin to = 1'b1; break; end
    end
    chk("ignore timeout", 32'(to), 32'd0);
    chk("ignore latency", 32'(n), 32'd8);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;   // during the done cycle
    @(negedge clk);
    start = 1'b0;
    repeat (12) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      @(negedge clk);
    end
    chk("ignore extra_activity", 32'(dones), 32'd0);
    chk("ignore quotient", 32'(quotient), 32'd22);
    chk("ignore remainder", 32'(remainder), 32'd2);

    // Reset during RUN aborts without a done.
    @(negedge clk);
    start = 1'b1; dividend = 8'd77; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort quotient", 32'(quotient), 32'd0);
    chk("abort remainder", 32'(remainder), 32'd0);
    chk("abort div_by_zero", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    chk("abort no_done", 32'(dones), 32'd0);
    run_and_check("after_abort", 8'd77, 8'd3, 8'd25, 8'd2, 1'b0);

    // Random sweep against the language operators.
    for (int i = 0; i < 600; i++) begin
      ra = 8'($urandom);
      rb = (i % 16 == 0) ? 8'd0 : 8'($urandom);
      do_div(ra, rb, n, bc, to);
      if (to) begin
        chk("rand timeout", 32'(to), 32'd0);
        break;
      end
      chk("rand quotient", 32'(quotient), (rb == 0) ? 32'hFF : 32'(ra / rb));
      chk("rand remainder", 32'(remainder), (rb == 0) ? 32'(ra) : 32'(ra % rb));
      chk("rand latency", 32'(n), (rb == 0) ? 32'd0 : 32'd8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_restoring_divider

`default_nettype wire
